// File: rtl/udp_table_cfg_ctrl.sv
// Configuration sequencer for the ping-pong UDP filter table: loads host entries
// into the shadow table, zero-fills the tail on commit, then requests a table swap.
module udp_table_cfg_ctrl #(
  parameter int U_DLY               = 1,
  parameter int UDP_TABLE_WIDTH     = 64,
  parameter int UDP_TABLE_DEPTH_BIT = 9,
  parameter int SWITCH_HOLD_CYC     = 8
) (
  input  logic                           clk_cfg,
  input  logic                           rst_cfg,
  input  logic                           entry_vld,
  input  logic [UDP_TABLE_WIDTH-1:0]     entry_data,
  input  logic                           commit,
  input  logic                           is_searching,
  output logic                           wr_en,
  output logic [UDP_TABLE_DEPTH_BIT-1:0] wr_addr,
  output logic [UDP_TABLE_WIDTH-1:0]     wr_data,
  output logic                           table_switch,
  output logic                           busy,
  output logic                           done,
  output logic [UDP_TABLE_DEPTH_BIT:0]   entry_num,
  output logic                           drop_err
);

  localparam int PW = UDP_TABLE_DEPTH_BIT + 1;
  localparam int HW = $clog2(SWITCH_HOLD_CYC + 1);
  localparam logic [PW-1:0] DEPTH     = {1'b1, {UDP_TABLE_DEPTH_BIT{1'b0}}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(SWITCH_HOLD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWITCH} state_e;

  state_e                         state_q, state_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                  fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]                  entry_num_pend_q, entry_num_pend_d;
  logic [PW-1:0]                  entry_num_q, entry_num_d;
  logic [HW-1:0]                  hold_cnt_q, hold_cnt_d;
  logic                           wr_en_q, wr_en_d;
  logic [UDP_TABLE_DEPTH_BIT-1:0] wr_addr_q, wr_addr_d;
  logic [UDP_TABLE_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                           table_switch_q, table_switch_d;
  logic                           done_q, done_d;
  logic                           drop_err_q, drop_err_d;
  logic [PW-1:0]                  ptr_nxt;

  // U_DLY is a simulation-only delay; the synthesizable flops do not use it.
  logic unused_dly;
  assign unused_dly = (U_DLY != 0);

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    fill_ptr_d       = fill_ptr_q;
    entry_num_pend_d = entry_num_pend_q;
    entry_num_d      = entry_num_q;
    hold_cnt_d       = '0;
    wr_en_d          = 1'b0;
    wr_addr_d        = '0;
    wr_data_d        = '0;
    table_switch_d   = 1'b0;
    done_d           = 1'b0;
    drop_err_d       = 1'b0;
    ptr_nxt          = wr_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (entry_vld) begin
          if (wr_ptr_q < DEPTH) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q[UDP_TABLE_DEPTH_BIT-1:0];
            wr_data_d = entry_data;
            ptr_nxt   = wr_ptr_q + 1'b1;
          end else begin
            drop_err_d = 1'b1;
          end
        end
        wr_ptr_d = ptr_nxt;
        // A same-cycle entry is counted before the fill point is latched.
        if (commit) begin
          entry_num_pend_d = ptr_nxt;
          fill_ptr_d       = ptr_nxt;
          state_d          = S_FILL;
        end
      end

      S_FILL: begin
        drop_err_d = entry_vld | commit;
        if (fill_ptr_q < DEPTH) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = fill_ptr_q[UDP_TABLE_DEPTH_BIT-1:0];
          fill_ptr_d = fill_ptr_q + 1'b1;
        end else begin
          state_d        = S_SWITCH;
          table_switch_d = 1'b1;
        end
      end

      S_SWITCH: begin
        drop_err_d     = entry_vld | commit;
        table_switch_d = 1'b1;
        // Swap request must stay up for a full idle window of the search engine.
        if (is_searching) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          table_switch_d = 1'b0;
          done_d         = 1'b1;
          entry_num_d    = entry_num_pend_q;
          wr_ptr_d       = '0;
          state_d        = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cfg) begin
    if (rst_cfg) begin
      state_q          <= S_IDLE;
      wr_ptr_q         <= '0;
      fill_ptr_q       <= '0;
      entry_num_pend_q <= '0;
      entry_num_q      <= '0;
      hold_cnt_q       <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      table_switch_q   <= 1'b0;
      done_q           <= 1'b0;
      drop_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      fill_ptr_q       <= fill_ptr_d;
      entry_num_pend_q <= entry_num_pend_d;
      entry_num_q      <= entry_num_d;
      hold_cnt_q       <= hold_cnt_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      table_switch_q   <= table_switch_d;
      done_q           <= done_d;
      drop_err_q       <= drop_err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign table_switch = table_switch_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign entry_num    = entry_num_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_udp_table_cfg_ctrl.sv
// Bench for udp_table_cfg_ctrl: vector table, directed corner cases, and random
// publishes scored against a table-image / hold-window model.
module tb_udp_table_cfg_ctrl;

  localparam int W     = 64;
  localparam int DB    = 9;
  localparam int DEPTH = 1 << DB;
  localparam int HOLD  = 8;

  logic          clk_cfg = 1'b0;
  logic          rst_cfg;
  logic          entry_vld;
  logic [W-1:0]  entry_data;
  logic          commit;
  logic          is_searching;
  logic          wr_en;
  logic [DB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          table_switch;
  logic          busy;
  logic          done;
  logic [DB:0]   entry_num;
  logic          drop_err;

  udp_table_cfg_ctrl dut (
    .clk_cfg(clk_cfg), .rst_cfg(rst_cfg), .entry_vld(entry_vld), .entry_data(entry_data),
    .commit(commit), .is_searching(is_searching), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .table_switch(table_switch), .busy(busy), .done(done),
    .entry_num(entry_num), .drop_err(drop_err)
  );

  always #5 clk_cfg = ~clk_cfg;

  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         exp_en;
    int           exp_addr;
    logic [W-1:0] exp_data;
    logic         exp_drop;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Model of what the shadow table should hold, plus observed write image.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] img[DEPTH];
  bit           pat[$];
  int wr_cnt, zero_cnt, drop_cnt, done_cnt, sw_len, order_bad, nxt_addr;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample outputs 1ns after the edge.
  task automatic step();
    @(posedge clk_cfg);
    #1;
    if (wr_en) begin
      img[wr_addr] = wr_data;
      wr_cnt++;
      if (wr_data == '0) zero_cnt++;
      if (int'(wr_addr) != nxt_addr) order_bad++;
      nxt_addr = int'(wr_addr) + 1;
    end
    if (drop_err)     drop_cnt++;
    if (done)         done_cnt++;
    if (table_switch) sw_len++;
  endtask

  task automatic begin_load();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) img[i] = 64'hBAD0_BAD0_BAD0_BAD0;
    nxt_addr  = 0;
    order_bad = 0;
    wr_cnt    = 0;
    zero_cnt  = 0;
  endtask

  task automatic load_entry(input logic [W-1:0] d);
    entry_vld  = 1'b1;
    entry_data = d;
    step();
    entry_vld = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  // Switch stays high until HOLD consecutive non-searching cycles have been seen.
  function automatic int exp_sw_len();
    int run = 0;
    for (int p = 0; p < 10000; p++) begin
      bit s = (p < pat.size()) ? pat[p] : 1'b0;
      run = s ? 0 : run + 1;
      if (run == HOLD) return p + 1;
    end
    return -1;
  endfunction

  task automatic publish(input string tag, input bit with_entry, input logic [W-1:0] d, input int inj);
    int k = 0;
    int inj_cnt = 0;
    int n, bad;
    drop_cnt = 0; done_cnt = 0; sw_len = 0;
    if (with_entry) begin
      entry_vld  = 1'b1;
      entry_data = d;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
    end
    commit = 1'b1;
    step();
    commit = 1'b0; entry_vld = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      if (i < inj) begin
        entry_vld  = (i % 2 == 0);
        commit     = (i % 2 == 1);
        entry_data = '1;
        inj_cnt++;
      end else begin
        entry_vld = 1'b0;
        commit    = 1'b0;
      end
      step();
      if (table_switch) begin
        is_searching = (k < pat.size()) ? pat[k] : 1'b0;
        k++;
      end else begin
        is_searching = 1'b0;
      end
    end
    entry_vld = 1'b0; commit = 1'b0; is_searching = 1'b0;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_entry_num"}, entry_num, n);
    chk({tag, "_switch_len"}, sw_len, exp_sw_len());
    chk({tag, "_drops"}, drop_cnt, inj_cnt);
    chk({tag, "_wr_cnt"}, wr_cnt, DEPTH);
    chk({tag, "_zero_cnt"}, zero_cnt, DEPTH - n);
    chk({tag, "_wr_order"}, order_bad, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (img[i] !== ((i < n) ? exp_q[i] : '0)) bad++;
    chk({tag, "_image"}, bad, 0);
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, {busy, table_switch}, 0);
  endtask

  vec_t vecs[5];

  initial begin
    rst_cfg = 1'b1; entry_vld = 1'b0; entry_data = '0; commit = 1'b0; is_searching = 1'b0;
    wr_cnt = 0; zero_cnt = 0; drop_cnt = 0; done_cnt = 0; sw_len = 0; order_bad = 0; nxt_addr = 0;
    repeat (3) step();
    rst_cfg = 1'b0;
    chk("rst_outputs", {wr_en, table_switch, busy, done, drop_err}, 0);
    chk("rst_entry_num", entry_num, 0);
    chk("rst_wr_addr_data", {wr_addr, wr_data}, 0);

    // Basic publish: vector table drives the load, then commit with idle search.
    vecs[0] = '{vld: 1'b1, data: 64'h1, exp_en: 1'b1, exp_addr: 0, exp_data: 64'h1, exp_drop: 1'b0};
    vecs[1] = '{vld: 1'b1, data: 64'h2, exp_en: 1'b1, exp_addr: 1, exp_data: 64'h2, exp_drop: 1'b0};
    vecs[2] = '{vld: 1'b0, data: 64'hFFFF, exp_en: 1'b0, exp_addr: 0, exp_data: 64'h0, exp_drop: 1'b0};
    vecs[3] = '{vld: 1'b1, data: 64'h3, exp_en: 1'b1, exp_addr: 2, exp_data: 64'h3, exp_drop: 1'b0};
    vecs[4] = '{vld: 1'b0, data: 64'h0, exp_en: 1'b0, exp_addr: 0, exp_data: 64'h0, exp_drop: 1'b0};
    begin_load();
    for (int i = 0; i < 5; i++) begin
      entry_vld = vecs[i].vld; entry_data = vecs[i].data;
      step();
      if (vecs[i].vld) exp_q.push_back(vecs[i].data);
      entry_vld = 1'b0;
      chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].exp_en);
      chk($sformatf("vec%0d_wr_addr", i), wr_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_drop", i), drop_err, vecs[i].exp_drop);
    end
    pat.delete();
    publish("basic", 1'b0, '0, 0);

    // Search stall, then stall with a short idle glitch that must not finish early.
    begin_load();
    load_entry(64'hA5);
    pat.delete();
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    publish("stall", 1'b0, '0, 0);
    begin_load();
    pat.delete();
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    for (int i = 0; i < 3; i++)  pat.push_back(1'b0);
    for (int i = 0; i < 5; i++)  pat.push_back(1'b1);
    publish("glitch", 1'b0, '0, 0);

    // Simultaneous entry + commit at wr_ptr=5, with host traffic during FILL.
    begin_load();
    for (int i = 0; i < 5; i++) load_entry(64'h100 + 64'(i));
    pat.delete();
    publish("simul", 1'b1, 64'hCAFE, 7);

    // Full table: 513th entry dropped, commit does no zero-fill.
    begin_load();
    for (int i = 0; i < DEPTH; i++) load_entry(64'h1000 + 64'(i));
    entry_vld = 1'b1; entry_data = 64'hABC;
    step();
    entry_vld = 1'b0;
    chk("full_drop", drop_err, 1);
    chk("full_no_write", wr_en, 0);
    step();
    chk("full_drop_pulse", drop_err, 0);
    pat.delete();
    publish("full", 1'b0, '0, 0);

    // Reset in the middle of SWITCH, then a clean reload.
    begin_load();
    load_entry(64'h11); load_entry(64'h22);
    commit = 1'b1; step(); commit = 1'b0;
    is_searching = 1'b1;
    for (int i = 0; i < 600 && !table_switch; i++) step();
    chk("mid_sw_reached", table_switch, 1);
    repeat (3) step();
    rst_cfg = 1'b1; done_cnt = 0;
    step();
    rst_cfg = 1'b0; is_searching = 1'b0;
    chk("mid_rst_outputs", {table_switch, busy, done, wr_en}, 0);
    chk("mid_rst_no_done", done_cnt, 0);
    begin_load();
    load_entry(64'h77);
    chk("mid_rst_reload_addr", {wr_en, wr_addr}, {1'b1, 9'd0});
    pat.delete();
    publish("after_rst", 1'b0, '0, 0);

    // Random publishes.
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(0, 40);
      begin_load();
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) step();
        load_entry({32'($urandom), 32'($urandom)} | 64'h1);
      end
      pat.delete();
      for (int j = 0; j < int'($urandom_range(0, 30)); j++) pat.push_back(1'($urandom_range(0, 1)));
      publish($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)} | 64'h1,
              $urandom_range(0, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_table_cfg_ctrl.md
Name: udp_table_cfg_ctrl

Overview:
- Configuration sequencer for the ping-pong UDP filter table manager.
- Takes a stream of filter entries from the host register interface and writes them in order into the shadow table.
- On commit, zero-fills the unused tail of the shadow table, then drives table_switch with the required hold-until-idle handshake so the manager swaps active and shadow tables.
- Runs entirely in the clk_cfg domain; the table manager resynchronises table_switch into its own domains.

Parameters:
U_DLY, 1, simulation delay on non-reset register assignments
UDP_TABLE_WIDTH, 64, entry width: reserved(16)+dst_ip(32)+dst_port(16)
UDP_TABLE_DEPTH_BIT, 9, table address width; depth = 2**UDP_TABLE_DEPTH_BIT
SWITCH_HOLD_CYC, 8, minimum cycles table_switch stays high after is_searching is seen low

Ports:
- clk_cfg  in  1  configuration clock
- rst_cfg  in  1  synchronous, active-high reset
- entry_vld  in  1  host entry strobe, one entry per cycle
- entry_data  in  UDP_TABLE_WIDTH  host entry
- commit  in  1  single-cycle request to publish the loaded entries
- is_searching  in  1  search engine busy on the active table; treat as already synchronised to clk_cfg
- wr_en  out  1  shadow table write enable, to table manager
- wr_addr  out  UDP_TABLE_DEPTH_BIT  shadow table write address
- wr_data  out  UDP_TABLE_WIDTH  shadow table write data
- table_switch  out  1  table swap request; the manager swaps on its falling edge
- busy  out  1  high in FILL and SWITCH
- done  out  1  one-cycle pulse when a switch completes
- entry_num  out  UDP_TABLE_DEPTH_BIT+1  number of valid entries in the last published table
- drop_err  out  1  one-cycle pulse when an entry or commit is discarded

Behaviour:
- Reset (synchronous):
  - state=IDLE, wr_ptr=0, fill_ptr=0, hold_cnt=0.
  - All outputs 0.
- State machine: IDLE -> FILL -> SWITCH -> IDLE.
- IDLE:
  - entry_vld with wr_ptr<DEPTH: wr_en=1, wr_addr=wr_ptr, wr_data=entry_data on the next cycle (1-cycle registered latency); wr_ptr+1.
  - entry_vld with wr_ptr==DEPTH: entry not written, drop_err pulses next cycle, wr_ptr unchanged.
  - commit: latch entry_num_pend=wr_ptr, fill_ptr=wr_ptr, go to FILL.
  - entry_vld and commit in the same cycle: the entry is written and counted first (entry_num_pend=wr_ptr+1, fill starts after it).
- FILL:
  - busy=1.
  - While fill_ptr<DEPTH, one write per cycle: wr_addr=fill_ptr, wr_data=0, wr_en=1; fill_ptr+1.
  - When fill_ptr==DEPTH, go to SWITCH. If commit arrived with a full table, FILL lasts exactly one cycle with no write.
  - An all-zero entry means "invalid".
- SWITCH:
  - busy=1, table_switch=1 (registered; rises the cycle after entry).
  - hold_cnt resets to 0 whenever is_searching=1; otherwise it increments.
  - When hold_cnt==SWITCH_HOLD_CYC-1 with is_searching=0: next cycle table_switch=0, done=1, entry_num=entry_num_pend, wr_ptr=0, state=IDLE.
  - table_switch is never high for fewer than SWITCH_HOLD_CYC cycles.
  - A stuck-high is_searching keeps SWITCH indefinitely; there is no timeout.
- While busy:
  - entry_vld and commit are discarded; each discarded cycle pulses drop_err one cycle later.
  - wr_en is driven only by the fill logic.
- wr_en=0 drives wr_addr=0 and wr_data=0.
- Width rules:
  - wr_ptr and fill_ptr are UDP_TABLE_DEPTH_BIT+1 bits, so DEPTH is representable.
  - wr_addr is the low UDP_TABLE_DEPTH_BIT bits of the pointer.
  - No wrap-around: pointers saturate at DEPTH.
- Reset mid-operation: returns to IDLE the next cycle and drops table_switch without a done pulse. The manager does see that falling edge and swaps. This is accepted: the host must reload after reset.
- The first commit after reset is required before the manager's read side becomes valid.

Test Plan:
- Basic publish: 3 entries (0x...0001, 0x...0002, 0x...0003), then commit, is_searching=0.
  -> Writes at addr 0,1,2 with that data, then zero writes at addr 3..511 (509 cycles).
  -> table_switch high exactly 8 cycles, then done=1 and entry_num=3.
- Search stall: commit while is_searching=1 for 20 cycles.
  -> table_switch stays high 20+8 cycles.
  -> An is_searching glitch to 0 for 3 cycles restarts hold_cnt; no early drop.
- Full table: 512 entries, then a 513th.
  -> The 513th gives drop_err=1 with no write.
  -> Commit skips the zero writes; entry_num=512.
- Simultaneous: entry_vld and commit in the same cycle with wr_ptr=5.
  -> Entry written at addr 5, fill starts at addr 6, entry_num=6.
- Busy discard: entry_vld and commit during FILL.
  -> drop_err pulses once per offending cycle; no host data reaches wr_data; a single done.
- Reset mid-SWITCH: rst_cfg for 1 cycle.
  -> Next cycle table_switch=0, busy=0, done=0, wr_ptr=0.
  -> A fresh load and commit then completes normally.
